// File: rtl/axis_frame_arbiter.sv
// Two-input AXI-Stream frame arbiter with round-robin grant,
// forced tlast after MAX_BEATS beats, and per-port frame counters.
module axis_frame_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      axis_aclk,
    input  logic                      axis_areset,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                      s00_axis_tvalid,
    input  logic                      s00_axis_tlast,
    output logic                      s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
    input  logic                      s01_axis_tvalid,
    input  logic                      s01_axis_tlast,
    output logic                      s01_axis_tready,
    output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                      m00_axis_tvalid,
    output logic                      m00_axis_tlast,
    input  logic                      m00_axis_tready,
    output logic [1:0]                grant,
    output logic [CNT_WIDTH-1:0]      frame_cnt0,
    output logic [CNT_WIDTH-1:0]      frame_cnt1,
    output logic                      overrun
);

    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0]           state_q, state_d;
    // last_q = 1 means s01 was served last, so s00 is favoured
    logic                 last_q, last_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic                 ovr_q, ovr_d;

    logic src_last;
    logic forced;
    logic hs;

    // Route the granted requester to m00; everything idles to zero
    always_comb begin
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tvalid = 1'b0;
        src_last        = 1'b0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        case (state_q)
            GRANT0: begin
                m00_axis_tdata  = s00_axis_tdata;
                m00_axis_tstrb  = s00_axis_tstrb;
                m00_axis_tvalid = s00_axis_tvalid;
                src_last        = s00_axis_tlast;
                s00_axis_tready = m00_axis_tready;
            end
            GRANT1: begin
                m00_axis_tdata  = s01_axis_tdata;
                m00_axis_tstrb  = s01_axis_tstrb;
                m00_axis_tvalid = s01_axis_tvalid;
                src_last        = s01_axis_tlast;
                s01_axis_tready = m00_axis_tready;
            end
            default: ;
        endcase
    end

    assign forced         = (beat_q == BEAT_W'(MAX_BEATS - 1));
    assign m00_axis_tlast = (state_q != IDLE) && (src_last || forced);
    assign hs             = m00_axis_tvalid && m00_axis_tready;

    assign grant      = {state_q == GRANT1, state_q == GRANT0};
    assign frame_cnt0 = cnt0_q;
    assign frame_cnt1 = cnt1_q;
    assign overrun    = ovr_q;

    // Arbitration, beat counting and frame-end bookkeeping
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (s00_axis_tvalid && (!s01_axis_tvalid || last_q))
                        state_d = GRANT0;
                    else if (s01_axis_tvalid)
                        state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (hs) begin
                    if (m00_axis_tlast) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        last_d  = (state_q == GRANT1);
                        if (state_q == GRANT0)
                            cnt0_d = cnt0_q + CNT_WIDTH'(1);
                        else
                            cnt1_d = cnt1_q + CNT_WIDTH'(1);
                        if (!src_last)
                            ovr_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: tdata width in bits; tstrb width is DATA_WIDTH/8.
REQ-002 Parameter MAX_BEATS, default 64: maximum beats per granted frame before a forced tlast.
REQ-003 Parameter CNT_WIDTH, default 16: width of each per-port frame counter.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 axis_aclk  in  1  sole clock; all state changes on its rising edge.
REQ-006 axis_areset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  permits new grants; has no effect on a frame already granted.
REQ-008 s00_axis_tdata / tstrb / tvalid / tlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  requester 0 stream.
REQ-009 s00_axis_tready  out  1  requester 0 ready.
REQ-010 s01_axis_tdata / tstrb / tvalid / tlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  requester 1 stream.
REQ-011 s01_axis_tready  out  1  requester 1 ready.
REQ-012 m00_axis_tdata / tstrb / tvalid / tlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  arbitrated stream toward the memory wrapper.
REQ-013 m00_axis_tready  in  1  downstream ready.
REQ-014 grant  out  2  one-hot grant indicator; 2'b00 when idle.
REQ-015 frame_cnt0, frame_cnt1  out  CNT_WIDTH  completed-frame counters for requester 0 and requester 1.
REQ-016 overrun  out  1  sticky flag; set when any tlast has been forced.

Function
REQ-017 FSM states: IDLE, GRANT0, GRANT1.
REQ-018 IDLE -> GRANTx on the clock edge where enable=1 and sx_axis_tvalid=1; grant takes effect the following cycle, giving one cycle of arbitration latency.
REQ-019 Both tvalid high in IDLE: the requester not served last wins; the round-robin pointer resets to favour s00.
REQ-020 In GRANTx: m00 tdata/tstrb/tvalid = sx values, combinational; sx_axis_tready = m00_axis_tready; the other requester's tready = 0.
REQ-021 In IDLE: m00_axis_tvalid = 0, m00 tdata/tstrb/tlast = 0, both s tready = 0.
REQ-022 A beat counter counts m00 handshakes (tvalid & tready) within a frame; it clears on frame end.
REQ-023 Frame end: handshake with m00_axis_tlast=1 -> IDLE next cycle; pointer records x; frame_cntx increments by 1, wrapping to 0 from all-ones.
REQ-024 m00_axis_tlast = sx_axis_tlast OR (beat counter = MAX_BEATS-1).
REQ-025 Forced tlast handshake without a source tlast: set overrun; the frame still ends as in REQ-023, and the remaining source beats form a new frame arbitrated normally.
REQ-026 enable dropped mid-frame: the current frame completes; no new grant is issued until enable=1.
REQ-027 Source tvalid dropped mid-frame: the grant holds, and m00_axis_tvalid follows the source.
REQ-028 tvalid=0 on both requesters in IDLE: remain in IDLE; no counter changes.
REQ-029 Minimum gap between frames: 1 IDLE cycle; back-to-back frames from the same requester are allowed if the other requester is not valid.

Reset
REQ-030 While axis_areset=1, independent of the clock: state=IDLE, grant=2'b00, pointer favours s00, beat counter=0, frame_cnt0=frame_cnt1=0, overrun=0, all tready=0, m00_axis_tvalid=0.
REQ-031 Reset asserted mid-frame aborts the frame; no counter increments; after release, arbitration restarts per REQ-018.

Verification
REQ-032 s00 sends a 4-beat frame with m00_axis_tready=1 -> grant=01 one cycle after tvalid; 4 beats out unchanged with tlast on beat 4; frame_cnt0=1; grant=00 afterward.
REQ-033 s00 and s01 continuously valid with 3-beat frames -> grants alternate 01,10,01,10; after 4 frames frame_cnt0=2 and frame_cnt1=2.
REQ-034 With MAX_BEATS=64, s01 sends 70 beats with no tlast -> m00 tlast on beat 64; overrun=1; frame_cnt1=1; the remaining 6 beats arrive as a new granted frame.
REQ-035 m00_axis_tready toggles 1,0 each cycle during an 8-beat frame -> the granted s tready mirrors it; data order is preserved; there are no duplicate or lost beats.
REQ-036 axis_areset pulsed at beat 2 of a 5-beat frame -> all outputs reach reset values immediately; frame_cnt0 stays 0; after release a new frame is granted normally.
REQ-037 enable=0 while both requesters are valid -> grant stays 00; setting enable=1 -> grant=01 within 1 cycle.
